// File: rtl/xor_frame_accumulator_pkg.sv
// xor_frame_accumulator_pkg: shared state encoding and sizing helper for the frame accumulator.
package xor_frame_accumulator_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
    endfunction
endpackage

// File: rtl/xor_frame_accumulator_xor_vec.sv
// xor_vec_using_mux: bitwise XOR built purely from 2:1 mux cells and constants.
module xor_mux2 (
    input  logic sel,
    input  logic a0,
    input  logic a1,
    output logic y
);
    assign y = sel ? a1 : a0;
endmodule

module xor_vec_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic na;
        // first mux inverts a, second picks a or ~a by b
        xor_mux2 u_inv (.sel(a[i]), .a0(1'b1), .a1(1'b0), .y(na));
        xor_mux2 u_sel (.sel(b[i]), .a0(a[i]), .a1(na), .y(y[i]));
    end
endmodule

// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator: XORs FRAME_LEN upstream words into one result with parity, valid/ready on both sides.
module xor_frame_accumulator
    import xor_frame_accumulator_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    output logic             down_parity,
    input  logic             down_ready
);
    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, acc_xor, par;
    logic accept;
    xor_vec_using_mux #(.WIDTH(WIDTH)) u_xor (.a(acc), .b(up_data), .y(acc_xor));
    assign up_ready   = state != OUTPUT;
    assign down_valid = state == OUTPUT;
    assign down_data  = down_valid ? acc : '0;
    assign accept     = up_valid && up_ready;
    // parity ripples through single-bit xor cells: par[g] = ^down_data[g:0]
    assign par[0] = down_data[0];
    for (genvar g = 1; g < WIDTH; g++) begin : g_par
        xor_vec_using_mux #(.WIDTH(1)) u_px (.a(par[g-1]), .b(down_data[g]), .y(par[g]));
    end
    assign down_parity = par[WIDTH-1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc_nxt   = up_data;
                    cnt_nxt   = CW'(1);
                    state_nxt = (FRAME_LEN == 1) ? OUTPUT : ACCUM;
                end
                ACCUM: if (accept) begin
                    acc_nxt   = acc_xor;
                    cnt_nxt   = cnt + CW'(1);
                    state_nxt = (cnt == LAST) ? OUTPUT : ACCUM;
                end
                OUTPUT: if (down_ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xor_frame_accumulator.sv
// tb_xor_frame_accumulator: directed and streaming checks of the frame accumulator (FRAME_LEN 4 and 1).
module tb_xor_frame_accumulator;
    import xor_frame_accumulator_pkg::*;
    logic clk = 0, rst = 0;
    logic clear = 0, up_valid = 0, down_ready = 0;
    logic [7:0] up_data = '0;
    logic up_ready, down_valid, down_parity;
    logic [7:0] down_data;
    logic clear_1 = 0, up_valid_1 = 0, down_ready_1 = 0;
    logic [7:0] up_data_1 = '0;
    logic up_ready_1, down_valid_1, down_parity_1;
    logic [7:0] down_data_1;
    int checks = 0, passes = 0;
    logic [7:0] q[$];
    logic [7:0] m_acc, exp_d;
    int m_n = 0, delivered = 0;
    xor_frame_accumulator #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .up_valid(up_valid), .up_data(up_data),
        .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
        .down_parity(down_parity), .down_ready(down_ready)
    );
    xor_frame_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear_1), .up_valid(up_valid_1), .up_data(up_data_1),
        .up_ready(up_ready_1), .down_valid(down_valid_1), .down_data(down_data_1),
        .down_parity(down_parity_1), .down_ready(down_ready_1)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_up_ready"}, 32'(up_ready), 1);
        check({tag, "_down_valid"}, 32'(down_valid), 0);
        check({tag, "_down_data"}, 32'(down_data), 0);
        check({tag, "_down_parity"}, 32'(down_parity), 0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "_cnt"}, 32'(dut.cnt), 0);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] d);
        up_valid = 1;
        up_data  = d;
        step();
        up_valid = 0;
    endtask
    task automatic check_result(input string tag, input logic [7:0] d, input logic p);
        check({tag, "_valid"}, 32'(down_valid), 1);
        check({tag, "_data"}, 32'(down_data), 32'(d));
        check({tag, "_parity"}, 32'(down_parity), 32'(p));
    endtask
    initial begin
        #3 check_reset("por");
        #5 rst = 1;
        // basic frame, downstream always ready
        down_ready = 1;
        send(8'h01); send(8'h02); send(8'h04);
        check("t1_early_valid", 32'(down_valid), 0);
        send(8'h08);
        check_result("t1", 8'h0F, 1'b0);
        step();
        check("t1_after_valid", 32'(down_valid), 0);
        check("t1_after_data", 32'(down_data), 0);
        check("t1_after_up_ready", 32'(up_ready), 1);
        // backpressure holds result stable
        down_ready = 0;
        send(8'hFF); send(8'h0F); send(8'h00); send(8'h01);
        for (int i = 0; i < 5; i++) begin
            check_result("t2_hold", 8'hF1, 1'b1);
            check("t2_up_ready", 32'(up_ready), 0);
            step();
        end
        check_result("t2_last", 8'hF1, 1'b1);
        down_ready = 1;
        step();
        check("t2_state", 32'(dut.state), 32'(IDLE));
        check("t2_valid", 32'(down_valid), 0);
        check("t2_up_ready", 32'(up_ready), 1);
        // FRAME_LEN = 1 instance
        up_valid_1 = 1; up_data_1 = 8'hA5;
        step();
        up_valid_1 = 0;
        check("t3_valid", 32'(down_valid_1), 1);
        check("t3_data", 32'(down_data_1), 32'hA5);
        check("t3_parity", 32'(down_parity_1), 0);
        check("t3_up_ready", 32'(up_ready_1), 0);
        down_ready_1 = 1;
        step();
        check("t3_after_valid", 32'(down_valid_1), 0);
        check("t3_after_up_ready", 32'(up_ready_1), 1);
        // clear mid-frame, word alongside clear is dropped
        send(8'h11); send(8'h22);
        clear = 1; up_valid = 1; up_data = 8'hFF;
        step();
        clear = 0; up_valid = 0;
        check("t4_state", 32'(dut.state), 32'(IDLE));
        check("t4_cnt", 32'(dut.cnt), 0);
        send(8'h03); send(8'h05); send(8'h06);
        check("t4_early_valid", 32'(down_valid), 0);
        send(8'h0C);
        check_result("t4", 8'h0C, 1'b0);
        step();
        // clear drops a pending result
        down_ready = 0;
        send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        check("t4b_valid", 32'(down_valid), 1);
        clear = 1;
        step();
        clear = 0;
        check("t4b_dropped", 32'(down_valid), 0);
        check("t4b_up_ready", 32'(up_ready), 1);
        // async reset during ACCUM
        down_ready = 1;
        send(8'h01); send(8'h02);
        #2 rst = 0;
        #1 check_reset("t5a");
        #2 rst = 1;
        send(8'h10); send(8'h20); send(8'h40); send(8'h80);
        check_result("t5a_frame", 8'hF0, 1'b0);
        step();
        // async reset during OUTPUT
        down_ready = 0;
        send(8'h3C); send(8'h00); send(8'h00); send(8'h00);
        check_result("t5b_pending", 8'h3C, 1'b0);
        #2 rst = 0;
        #1 check_reset("t5b");
        #2 rst = 1;
        down_ready = 1;
        send(8'h07); send(8'h00); send(8'h00); send(8'h00);
        check_result("t5b_frame", 8'h07, 1'b1);
        step();
        // continuous stream with random backpressure against a model
        for (int i = 0; i < 305; i++) begin
            up_valid   = (i < 300);
            up_data    = 8'($urandom);
            down_ready = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (down_valid && down_ready) begin
                if (q.size() == 0) check("rand_spurious", 32'(down_valid), 0);
                else begin
                    exp_d = q.pop_front();
                    check("rand_data", 32'(down_data), 32'(exp_d));
                    check("rand_parity", 32'(down_parity), 32'(^exp_d));
                end
                delivered++;
            end
            if (up_valid && up_ready) begin
                m_acc = (m_n == 0) ? up_data : (m_acc ^ up_data);
                m_n++;
                if (m_n == 4) begin
                    q.push_back(m_acc);
                    m_n = 0;
                end
            end
            step();
        end
        check("rand_pending_left", 32'(q.size()), 0);
        check("rand_partial_cnt", 32'(dut.cnt), 32'(m_n));
        check("rand_some_delivered", 32'(delivered > 10), 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/xor_frame_accumulator.md
XOR_FRAME_ACCUMULATOR -- requirements
Module: xor_frame_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits (legal values 1 and up).
REQ-002 The block SHALL have parameter FRAME_LEN, default 4: words per frame (legal values 1 and up).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-006 The block SHALL have port up_valid, input, 1 bit: the upstream word is valid.
REQ-007 The block SHALL have port up_data, input, WIDTH bits: the upstream word.
REQ-008 The block SHALL have port up_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port down_valid, output, 1 bit: a frame result is available.
REQ-010 The block SHALL have port down_data, output, WIDTH bits: the bitwise XOR of all words in the frame.
REQ-011 The block SHALL have port down_parity, output, 1 bit: the XOR reduction of down_data.
REQ-012 The block SHALL have port down_ready, input, 1 bit: downstream takes the result.

Function
REQ-013 A word SHALL be accepted only in a cycle where up_valid and up_ready are both 1.
REQ-014 The FSM SHALL have three states: IDLE (no partial frame), ACCUM (1 to FRAME_LEN-1 words held) and OUTPUT (result pending).
REQ-015 up_ready SHALL be 1 in IDLE and ACCUM and 0 in OUTPUT; it SHALL be decoded from state only, with no combinational path from up_valid.
REQ-016 On acceptance in IDLE, the accumulator SHALL load up_data and the counter SHALL be set to 1.
REQ-017 On acceptance in ACCUM, the accumulator SHALL load accumulator XOR up_data and the counter SHALL increment.
REQ-018 Acceptance of the FRAME_LEN-th word SHALL move the FSM to OUTPUT, with down_valid=1 on the next cycle (1-cycle latency).
REQ-019 With FRAME_LEN=1, acceptance in IDLE SHALL go directly to OUTPUT.
REQ-020 Otherwise, the first acceptance SHALL move IDLE to ACCUM.
REQ-021 In OUTPUT, down_valid, down_data and down_parity SHALL stay stable until the cycle in which down_valid and down_ready are both 1; the FSM SHALL then return to IDLE with the counter at 0.
REQ-022 down_ready SHALL be ignored outside OUTPUT.
REQ-023 down_valid SHALL be 1 only in OUTPUT.
REQ-024 down_data and down_parity SHALL be 0 whenever down_valid is 0.
REQ-025 The counter SHALL be max(1,$clog2(FRAME_LEN+1)) bits wide and SHALL never exceed FRAME_LEN.
REQ-026 clear=1 SHALL have priority in every state: next state IDLE, counter 0, accumulator 0, any pending result dropped.
REQ-027 A word presented in the same cycle as clear SHALL be discarded.
REQ-028 clear asserted in the same cycle as a down handshake SHALL count the result as delivered.
REQ-029 Back-to-back frames SHALL need one IDLE cycle between them: up_ready returns to 1 in the cycle after the down handshake.

Reset
REQ-030 Assertion of rst (low) SHALL asynchronously force: state IDLE, counter 0, accumulator 0, down_valid 0, down_data 0, down_parity 0, up_ready 1.
REQ-031 Reset asserted mid-frame or during OUTPUT SHALL discard all partial and pending data.
REQ-032 Deassertion of rst SHALL take effect on a clk edge; the first word SHALL be accepted on the first rising edge with rst high.

Structure
REQ-033 The state enum (IDLE, ACCUM, OUTPUT) SHALL be defined in shared package xor_frame_accumulator_pkg.
REQ-034 Bitwise XOR SHALL be done by sub-module xor_vec_using_mux (parameter WIDTH), built only from mux instances, constants 0/1 and wires.
REQ-035 The same sub-module style SHALL be used for the parity reduction, as a chain of WIDTH-1 single-bit mux-based XOR cells.

Verification
REQ-036 With WIDTH=8 and FRAME_LEN=4, the bench SHALL send 0x01, 0x02, 0x04, 0x08 with down_ready=1 and check down_valid=1 for 1 cycle the cycle after the 4th accept, with down_data=0x0F and down_parity=0.
REQ-037 The bench SHALL send frame 0xFF, 0x0F, 0x00, 0x01 with down_ready=0 for 5 cycles and check down_data=0xF1 and down_parity=1 held stable, up_ready=0 throughout, and IDLE after the handshake.
REQ-038 With FRAME_LEN=1, the bench SHALL send 0xA5 and check down_data=0xA5 and down_parity=0 one cycle later.
REQ-039 The bench SHALL pulse clear after 2 words, then send 0x03, 0x05, 0x06, 0x0C and check down_data=0x0C (the pre-clear words are excluded).
REQ-040 The bench SHALL assert rst low asynchronously (mid-cycle) during ACCUM and again during OUTPUT and check that the outputs immediately match REQ-030 and that the next full frame is correct.
REQ-041 The bench SHALL drive up_valid=1 continuously with random data and random down_ready and check, against a model, that exactly FRAME_LEN words go into each result and that no word is lost or duplicated.
